// File: rtl/fifo_uart_stream_ctrl.sv
// fifo_uart_stream_ctrl
// Drains the capture FIFO once the trigger block reports it full, sends every
// sample as BYTES little-endian UART bytes followed by a terminator byte, then
// re-arms the trigger block. A separate UART receive parser accepts mask-update
// commands. A received mask is applied only while the transmitter is idle, so
// the trigger mask never changes in the middle of a dump.

module fifo_uart_stream_ctrl #(
    parameter int         CHANNELS  = 3,
    parameter logic [7:0] TERM_CHAR = 8'h0A,
    parameter logic [7:0] CMD_MASK  = 8'h4D
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_wrfull,
    input  logic                fifo_rdempty,
    input  logic [CHANNELS-1:0] fifo_q,
    output logic                fifo_rdreq,
    input  logic                uart_txempty,
    output logic [7:0]          uart_tx_data,
    output logic                uart_ld_tx_data,
    input  logic                uart_rxempty,
    input  logic [7:0]          uart_rx_data,
    output logic                uart_uld_rx_data,
    output logic                uart_rst,
    output logic                trig_syncrst,
    output logic [CHANNELS-1:0] trig_mask,
    output logic [3:0]          state_debug
);

    localparam int BYTES = (CHANNELS + 7) / 8;
    localparam int SW    = 8 * BYTES;
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [3:0] {
        INIT        = 4'd0,
        IDLE        = 4'd1,
        READ        = 4'd2,
        CAPTURE     = 4'd3,
        WAIT_TX     = 4'd4,
        LOAD        = 4'd5,
        WAIT_ACCEPT = 4'd6,
        SEND_TERM   = 4'd7,
        WAIT_TERM   = 4'd8
    } tx_state_t;

    typedef enum logic {
        RX_WAIT = 1'b0,
        RX_HOLD = 1'b1
    } rx_state_t;

    tx_state_t            tx_state_q, tx_state_d;
    logic [SW-1:0]        sample_q, sample_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [7:0]           tx_byte;

    rx_state_t            rx_state_q, rx_state_d;
    logic                 cmd_open_q, cmd_open_d;
    logic [IW-1:0]        cmd_cnt_q, cmd_cnt_d;
    logic [SW-1:0]        cmd_buf_q, cmd_buf_d;
    logic [CHANNELS-1:0]  pend_mask_q, pend_mask_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [CHANNELS-1:0]  trig_mask_q, trig_mask_d;

    // Select the byte of the captured sample addressed by the byte index.
    always_comb begin
        tx_byte = 8'h00;
        for (int b = 0; b < BYTES; b++) begin
            if (idx_q == IW'(b)) begin
                tx_byte = sample_q[8*b +: 8];
            end
        end
    end

    // Transmit FSM: next state and the FIFO, UART and trigger controls it drives.
    always_comb begin
        tx_state_d      = tx_state_q;
        sample_d        = sample_q;
        idx_d           = idx_q;
        fifo_rdreq      = 1'b0;
        uart_ld_tx_data = 1'b0;
        uart_tx_data    = 8'h00;
        uart_rst        = 1'b0;
        trig_syncrst    = 1'b1;
        case (tx_state_q)
            INIT: begin
                uart_rst   = 1'b1;
                tx_state_d = IDLE;
            end
            IDLE: begin
                trig_syncrst = 1'b0;
                if (fifo_wrfull) begin
                    tx_state_d = READ;
                end
            end
            READ: begin
                fifo_rdreq = 1'b1;
                tx_state_d = CAPTURE;
            end
            CAPTURE: begin
                sample_d   = SW'(fifo_q);
                idx_d      = '0;
                tx_state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (uart_txempty) begin
                    tx_state_d = LOAD;
                end
            end
            LOAD: begin
                uart_ld_tx_data = 1'b1;
                uart_tx_data    = tx_byte;
                if (!uart_txempty) begin
                    tx_state_d = WAIT_ACCEPT;
                end
            end
            WAIT_ACCEPT: begin
                if (uart_txempty) begin
                    if (int'(idx_q) < BYTES - 1) begin
                        idx_d      = idx_q + IW'(1);
                        tx_state_d = LOAD;
                    end else if (fifo_rdempty) begin
                        tx_state_d = SEND_TERM;
                    end else begin
                        tx_state_d = READ;
                    end
                end
            end
            SEND_TERM: begin
                uart_ld_tx_data = 1'b1;
                uart_tx_data    = TERM_CHAR;
                if (!uart_txempty) begin
                    tx_state_d = WAIT_TERM;
                end
            end
            WAIT_TERM: begin
                if (uart_txempty) begin
                    tx_state_d = IDLE;
                end
            end
            default: begin
                tx_state_d = INIT;
            end
        endcase
    end

    // Transmit FSM registers; a reset abandons any dump in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= INIT;
            sample_q   <= '0;
            idx_q      <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            sample_q   <= sample_d;
            idx_q      <= idx_d;
        end
    end

    // Receive parser, mask-command decode, and commit of a pending mask while idle.
    always_comb begin
        rx_state_d       = rx_state_q;
        uart_uld_rx_data = 1'b0;
        cmd_open_d       = cmd_open_q;
        cmd_cnt_d        = cmd_cnt_q;
        cmd_buf_d        = cmd_buf_q;
        pend_mask_d      = pend_mask_q;
        pend_valid_d     = pend_valid_q;
        trig_mask_d      = trig_mask_q;

        if ((tx_state_q == IDLE) && pend_valid_q) begin
            trig_mask_d  = pend_mask_q;
            pend_valid_d = 1'b0;
        end

        case (rx_state_q)
            RX_WAIT: begin
                if (!uart_rxempty) begin
                    uart_uld_rx_data = 1'b1;
                    rx_state_d       = RX_HOLD;
                    if (!cmd_open_q) begin
                        if (uart_rx_data == CMD_MASK) begin
                            cmd_open_d = 1'b1;
                            cmd_cnt_d  = '0;
                            cmd_buf_d  = '0;
                        end
                    end else begin
                        for (int b = 0; b < BYTES; b++) begin
                            if (cmd_cnt_q == IW'(b)) begin
                                cmd_buf_d[8*b +: 8] = uart_rx_data;
                            end
                        end
                        if (int'(cmd_cnt_q) == BYTES - 1) begin
                            pend_mask_d  = cmd_buf_d[CHANNELS-1:0];
                            pend_valid_d = 1'b1;
                            cmd_open_d   = 1'b0;
                        end else begin
                            cmd_cnt_d = cmd_cnt_q + IW'(1);
                        end
                    end
                end
            end
            RX_HOLD: begin
                rx_state_d = RX_WAIT;
            end
            default: begin
                rx_state_d = RX_WAIT;
            end
        endcase
    end

    // Receive-side registers; the trigger mask comes out of reset fully enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_WAIT;
            cmd_open_q   <= 1'b0;
            cmd_cnt_q    <= '0;
            cmd_buf_q    <= '0;
            pend_mask_q  <= '0;
            pend_valid_q <= 1'b0;
            trig_mask_q  <= '1;
        end else begin
            rx_state_q   <= rx_state_d;
            cmd_open_q   <= cmd_open_d;
            cmd_cnt_q    <= cmd_cnt_d;
            cmd_buf_q    <= cmd_buf_d;
            pend_mask_q  <= pend_mask_d;
            pend_valid_q <= pend_valid_d;
            trig_mask_q  <= trig_mask_d;
        end
    end

    assign trig_mask   = trig_mask_q;
    assign state_debug = tx_state_q;

endmodule

// File: tb/tb_fifo_uart_stream_ctrl.sv
// Testbench for fifo_uart_stream_ctrl: a 3-channel and a 12-channel instance
// share the stimulus; use12 selects which one sees fifo_wrfull and which one's
// outputs feed the FIFO/UART model.

module tb_fifo_uart_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        use12;
    logic        wrfull, rdempty, txempty, rxempty;
    logic [11:0] fifo_data;
    logic [7:0]  rx_data;

    logic        d3_rdreq, d3_ld, d3_uld, d3_urst, d3_sync;
    logic [7:0]  d3_tx;
    logic [2:0]  d3_mask;
    logic [3:0]  d3_state;

    logic        d12_rdreq, d12_ld, d12_uld, d12_urst, d12_sync;
    logic [7:0]  d12_tx;
    logic [11:0] d12_mask;
    logic [3:0]  d12_state;

    logic        rdreq_m, ld_m, sync_m;
    logic [7:0]  tx_m;

    int checks = 0;
    int errors = 0;
    int uld_count = 0;
    int rdreq_cnt = 0;
    logic [11:0] fifo_model[$];
    logic [7:0]  got_bytes[$];
    logic [7:0]  exp_bytes[$];

    typedef struct packed {
        logic       wrfull;
        logic       rdempty;
        logic [2:0] q;
        logic       txempty;
        logic [3:0] st;
        logic       rdreq;
        logic       ld;
        logic [7:0] tx;
        logic       sync;
    } vec_t;

    vec_t vecs[21];

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    fifo_uart_stream_ctrl #(.CHANNELS(3), .TERM_CHAR(8'h0A), .CMD_MASK(8'h4D)) dut3 (
        .clk(clk), .rst(rst),
        .fifo_wrfull(wrfull & ~use12), .fifo_rdempty(rdempty), .fifo_q(fifo_data[2:0]),
        .fifo_rdreq(d3_rdreq),
        .uart_txempty(txempty), .uart_tx_data(d3_tx), .uart_ld_tx_data(d3_ld),
        .uart_rxempty(rxempty), .uart_rx_data(rx_data), .uart_uld_rx_data(d3_uld),
        .uart_rst(d3_urst), .trig_syncrst(d3_sync), .trig_mask(d3_mask),
        .state_debug(d3_state)
    );

    fifo_uart_stream_ctrl #(.CHANNELS(12), .TERM_CHAR(8'h0A), .CMD_MASK(8'h4D)) dut12 (
        .clk(clk), .rst(rst),
        .fifo_wrfull(wrfull & use12), .fifo_rdempty(rdempty), .fifo_q(fifo_data),
        .fifo_rdreq(d12_rdreq),
        .uart_txempty(txempty), .uart_tx_data(d12_tx), .uart_ld_tx_data(d12_ld),
        .uart_rxempty(1'b1), .uart_rx_data(8'h00), .uart_uld_rx_data(d12_uld),
        .uart_rst(d12_urst), .trig_syncrst(d12_sync), .trig_mask(d12_mask),
        .state_debug(d12_state)
    );

    assign rdreq_m = use12 ? d12_rdreq : d3_rdreq;
    assign ld_m    = use12 ? d12_ld    : d3_ld;
    assign sync_m  = use12 ? d12_sync  : d3_sync;
    assign tx_m    = use12 ? d12_tx    : d3_tx;

    // Count receive unload strobes of the 3-channel instance.
    always @(negedge clk) begin
        if (d3_uld) uld_count++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        wrfull    = v.wrfull;
        rdempty   = v.rdempty;
        fifo_data = {9'd0, v.q};
        txempty   = v.txempty;
    endtask

    task automatic buildExpected(input int bytes_per);
        logic [11:0] tmp;
        exp_bytes.delete();
        foreach (fifo_model[i]) begin
            for (int b = 0; b < bytes_per; b++) begin
                tmp = fifo_model[i] >> (8 * b);
                exp_bytes.push_back(tmp[7:0]);
            end
        end
        exp_bytes.push_back(8'h0A);
    endtask

    task automatic checkBytes(input string tag);
        checkOutput({tag, "_byte_count"}, got_bytes.size(), exp_bytes.size());
        foreach (exp_bytes[i]) begin
            if (i < got_bytes.size())
                checkOutput($sformatf("%s_byte%0d", tag, i), got_bytes[i], exp_bytes[i]);
        end
    endtask

    // Runs one full dump with a FIFO model and a UART that accepts each byte
    // accept_delay cycles after the load request appears.
    task automatic runDump(input int accept_delay, input logic [2:0] hold_mask);
        int         hold_cnt = 0;
        int         low_cnt = 0;
        logic [7:0] first_byte = 8'h00;
        bit         holding = 0, seen_busy = 0, done = 0;
        bit         stable_ok = 1, mask_ok = 1, pop, accept;
        got_bytes.delete();
        rdreq_cnt = 0;
        @(posedge clk);
        #1;
        wrfull  = 1'b1;
        txempty = 1'b1;
        rdempty = (fifo_model.size() == 0);
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk);
            if (sync_m) seen_busy = 1;
            if (seen_busy && !sync_m) done = 1;
            if (!use12 && seen_busy && !done && d3_mask !== hold_mask) mask_ok = 0;
            pop = rdreq_m;
            if (rdreq_m) rdreq_cnt++;
            accept = 0;
            if (ld_m && txempty) begin
                if (!holding) begin
                    holding    = 1;
                    first_byte = tx_m;
                    hold_cnt   = 0;
                end else if (tx_m !== first_byte) begin
                    stable_ok = 0;
                end
                if (hold_cnt >= accept_delay) begin
                    accept  = 1;
                    holding = 0;
                    got_bytes.push_back(first_byte);
                end else begin
                    hold_cnt++;
                end
            end
            if (!done) begin
                @(posedge clk);
                #1;
                if (pop) begin
                    wrfull = 1'b0;
                    if (fifo_model.size() > 0) fifo_data = fifo_model.pop_front();
                    rdempty = (fifo_model.size() == 0);
                end
                if (accept) begin
                    txempty = 1'b0;
                    low_cnt = 2;
                end else if (low_cnt > 0) begin
                    low_cnt--;
                    if (low_cnt == 0) txempty = 1'b1;
                end
            end
        end
        wrfull = 1'b0;
        checkOutput("dump_done_idle", done, 1);
        checkOutput("tx_hold_stable", stable_ok, 1);
        if (!use12) checkOutput("mask_hold_in_dump", mask_ok, 1);
    endtask

    task automatic sendRx(input logic [7:0] b);
        bit seen = 0;
        @(posedge clk);
        #1;
        rx_data = b;
        rxempty = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (d3_uld) seen = 1;
        end
        @(posedge clk);
        #1;
        rxempty = 1'b1;
        if (!seen) checkOutput("rx_uld_timeout", 0, 1);
    endtask

    initial begin
        bit reached = 0;

        //          wr   rde  q     txe  st    rdreq ld    tx     sync
        vecs[0]  = '{1'b0,1'b0,3'd0,1'b1,4'd1,1'b0,1'b0,8'h00,1'b0};
        vecs[1]  = '{1'b1,1'b0,3'd0,1'b1,4'd1,1'b0,1'b0,8'h00,1'b0};
        vecs[2]  = '{1'b1,1'b0,3'd0,1'b1,4'd2,1'b1,1'b0,8'h00,1'b1};
        vecs[3]  = '{1'b0,1'b0,3'd5,1'b1,4'd3,1'b0,1'b0,8'h00,1'b1};
        vecs[4]  = '{1'b0,1'b0,3'd0,1'b0,4'd4,1'b0,1'b0,8'h00,1'b1};
        vecs[5]  = '{1'b0,1'b0,3'd0,1'b1,4'd4,1'b0,1'b0,8'h00,1'b1};
        vecs[6]  = '{1'b0,1'b0,3'd0,1'b1,4'd5,1'b0,1'b1,8'h05,1'b1};
        vecs[7]  = '{1'b0,1'b0,3'd0,1'b0,4'd5,1'b0,1'b1,8'h05,1'b1};
        vecs[8]  = '{1'b0,1'b0,3'd0,1'b0,4'd6,1'b0,1'b0,8'h00,1'b1};
        vecs[9]  = '{1'b0,1'b0,3'd0,1'b1,4'd6,1'b0,1'b0,8'h00,1'b1};
        vecs[10] = '{1'b0,1'b0,3'd0,1'b1,4'd2,1'b1,1'b0,8'h00,1'b1};
        vecs[11] = '{1'b0,1'b0,3'd2,1'b1,4'd3,1'b0,1'b0,8'h00,1'b1};
        vecs[12] = '{1'b0,1'b0,3'd0,1'b1,4'd4,1'b0,1'b0,8'h00,1'b1};
        vecs[13] = '{1'b0,1'b0,3'd0,1'b1,4'd5,1'b0,1'b1,8'h02,1'b1};
        vecs[14] = '{1'b0,1'b1,3'd0,1'b0,4'd5,1'b0,1'b1,8'h02,1'b1};
        vecs[15] = '{1'b0,1'b1,3'd0,1'b1,4'd6,1'b0,1'b0,8'h00,1'b1};
        vecs[16] = '{1'b0,1'b1,3'd0,1'b1,4'd7,1'b0,1'b1,8'h0A,1'b1};
        vecs[17] = '{1'b0,1'b1,3'd0,1'b0,4'd7,1'b0,1'b1,8'h0A,1'b1};
        vecs[18] = '{1'b0,1'b1,3'd0,1'b0,4'd8,1'b0,1'b0,8'h00,1'b1};
        vecs[19] = '{1'b0,1'b1,3'd0,1'b1,4'd8,1'b0,1'b0,8'h00,1'b1};
        vecs[20] = '{1'b0,1'b1,3'd0,1'b1,4'd1,1'b0,1'b0,8'h00,1'b0};

        rst = 1'b1; use12 = 1'b0; wrfull = 1'b0; rdempty = 1'b1; txempty = 1'b1;
        rxempty = 1'b1; fifo_data = 12'h000; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // First cycle after reset release: INIT with reset output values.
        @(negedge clk);
        checkOutput("reset_d3", {d3_state, d3_urst, d3_sync, d3_rdreq, d3_ld, d3_tx, d3_uld, d3_mask},
                    {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'b111});
        checkOutput("reset_d12", {d12_urst, d12_uld, d12_mask}, {1'b1, 1'b0, 12'hFFF});

        // Cycle-exact two-sample dump: 0x05, 0x02, then the terminator.
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), {d3_state, d3_rdreq, d3_ld, d3_tx, d3_sync},
                        {vecs[i].st, vecs[i].rdreq, vecs[i].ld, vecs[i].tx, vecs[i].sync});
        end

        // UART holds off acceptance for 5 cycles on every byte.
        fifo_model = '{12'h006, 12'h001};
        buildExpected(1);
        runDump(5, 3'b111);
        checkBytes("slow_uart");
        checkOutput("slow_uart_rdreq", rdreq_cnt, 2);

        // Mask command while idle.
        uld_count = 0;
        sendRx(8'h4D);
        sendRx(8'h06);
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_mask_commit", d3_mask, 3'b110);
        checkOutput("idle_uld_pulses", uld_count, 2);

        // Same kind of command during a dump commits only back in IDLE.
        fifo_model = '{12'h003, 12'h004, 12'h007};
        buildExpected(1);
        fork
            runDump(3, 3'b110);
            begin
                sendRx(8'h4D);
                sendRx(8'h05);
            end
        join
        checkBytes("dump_cmd");
        @(posedge clk);
        @(negedge clk);
        checkOutput("dump_mask_commit", d3_mask, 3'b101);

        // Stray byte ignored, last of two complete commands wins.
        fifo_model = '{12'h001, 12'h002, 12'h003};
        buildExpected(1);
        fork
            runDump(4, 3'b101);
            begin
                sendRx(8'h41);
                sendRx(8'h4D);
                sendRx(8'h01);
                sendRx(8'h4D);
                sendRx(8'h03);
            end
        join
        @(posedge clk);
        @(negedge clk);
        checkOutput("last_cmd_wins", d3_mask, 3'b011);

        // 12-channel instance: one sample gives two data bytes then terminator.
        use12 = 1'b1;
        fifo_model = '{12'hABC};
        buildExpected(2);
        runDump(0, 3'b011);
        checkBytes("ch12");
        checkOutput("ch12_rdreq", rdreq_cnt, 1);
        use12 = 1'b0;

        // Reset asserted while the 3-channel instance sits in LOAD.
        @(posedge clk);
        #1;
        wrfull = 1'b1; txempty = 1'b1; fifo_data = 12'h005;
        for (int i = 0; i < 20 && !reached; i++) begin
            @(negedge clk);
            if (d3_state == 4'd5) reached = 1;
        end
        checkOutput("reach_load", reached, 1);
        rst = 1'b1;
        wrfull = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midload_reset", {d3_state, d3_urst, d3_sync, d3_rdreq, d3_ld, d3_tx, d3_mask},
                    {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'b111});
        @(negedge clk);
        checkOutput("post_init_idle", {d3_state, d3_urst, d3_sync}, {4'd1, 1'b0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_stream_ctrl.md
# fifo_uart_stream_ctrl

Parametrised successor to the capture-to-UART controller. It drains the sample FIFO once the trigger block has filled it and serialises each CHANNELS-wide sample into one or more UART bytes. A terminator byte follows each full FIFO dump, and the trigger block is then re-armed. A concurrent UART receive parser accepts mask-update commands, so the host sets the per-channel trigger mask at run time.

## Interface
- CHANNELS, 3: sample width, 1..32; BYTES = ceil(CHANNELS/8) bytes per sample.
- TERM_CHAR, 8'h0A: byte sent after each FIFO dump.
- CMD_MASK, 8'h4D: RX opcode introducing a mask update.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_wrfull  in  1  FIFO full; capture buffer ready to dump.
- fifo_rdempty  in  1  FIFO empty.
- fifo_q  in  CHANNELS  FIFO read data, valid the cycle after fifo_rdreq (non-showahead).
- fifo_rdreq  out  1  one-cycle read strobe.
- uart_txempty  in  1  UART TX holding buffer empty.
- uart_tx_data  out  8  byte presented to UART.
- uart_ld_tx_data  out  1  load request; held until UART accepts.
- uart_rxempty  in  1  UART RX buffer empty.
- uart_rx_data  in  8  received byte.
- uart_uld_rx_data  out  1  one-cycle RX unload strobe.
- uart_rst  out  1  UART reset.
- trig_syncrst  out  1  trigger-block reset; low only while armed.
- trig_mask  out  CHANNELS  per-channel trigger enable.
- state_debug  out  4  current TX FSM state code.

## Operation
- TX FSM states, in order: INIT, IDLE, READ, CAPTURE, WAIT_TX, LOAD, WAIT_ACCEPT, SEND_TERM, WAIT_TERM.
- INIT: uart_rst=1 and trig_syncrst=1 for one cycle, then go to IDLE.
- IDLE: trig_syncrst=0. If fifo_wrfull=1, go to READ.
- READ: fifo_rdreq=1 for one cycle, then go to CAPTURE.
- CAPTURE: register fifo_q zero-extended to 8*BYTES bits, clear the byte index, then go to WAIT_TX.
- WAIT_TX: wait for uart_txempty=1, then go to LOAD.
- LOAD: uart_ld_tx_data=1 and uart_tx_data = sample byte[index], least-significant byte first. Stay in LOAD while uart_txempty=1. When uart_txempty=0, go to WAIT_ACCEPT.
- WAIT_ACCEPT: wait for uart_txempty=1, then:
  - if index < BYTES-1: increment index and go to LOAD;
  - else if fifo_rdempty=1: go to SEND_TERM;
  - else: go to READ.
- SEND_TERM and WAIT_TERM: same handshake as LOAD and WAIT_ACCEPT, with uart_tx_data=TERM_CHAR. On completion go to IDLE, which re-arms the trigger.
- trig_syncrst=1 in every state except IDLE. uart_ld_tx_data=1 only in LOAD and SEND_TERM. uart_tx_data is held stable while uart_ld_tx_data=1.
- RX parser runs independently of the TX FSM:
  - States: RX_WAIT, RX_HOLD.
  - RX_WAIT: when uart_rxempty=0, assert uart_uld_rx_data for one cycle, latch uart_rx_data in that same cycle, then go to RX_HOLD.
  - RX_HOLD: lasts one cycle, covering the UART flag update latency; then return to RX_WAIT.
- Command decode:
  - When no command is open, a byte equal to CMD_MASK opens a command and clears the byte counter.
  - The next BYTES bytes fill pend_mask, least-significant byte first; bits above CHANNELS are discarded.
  - Once all BYTES bytes are received, pend_valid=1 and the command closes.
  - Any byte that is not CMD_MASK while no command is open is ignored.
- Mask commit:
  - trig_mask <= pend_mask only in a cycle where the TX FSM is in IDLE and pend_valid=1; pend_valid clears in that cycle.
  - The mask never changes mid-dump.
  - A second complete command before commit overwrites pend_mask; last complete command wins.
  - A partially received command does not disturb a pending pend_mask.

## Timing
- Reset values: state=INIT, RX state=RX_WAIT, trig_mask=all ones, pend_valid=0, command closed, fifo_rdreq=0, uart_ld_tx_data=0, uart_uld_rx_data=0, uart_tx_data=8'h00. uart_rst=1 and trig_syncrst=1 in the first cycle after reset release (INIT).
- Reset mid-dump: the dump is abandoned. The FIFO is not flushed by this block; the trigger block is held in reset through INIT.
- Latency from fifo_wrfull seen in IDLE: rdreq asserts next cycle; the first uart_ld_tx_data can assert 3 cycles after that (READ, CAPTURE, WAIT_TX).
- FIFO with K samples produces exactly K*BYTES data bytes, then one TERM_CHAR.
- fifo_rdempty is sampled only in WAIT_ACCEPT after the last byte of a sample. Since that is at least 2 cycles after rdreq, the FIFO flag has settled.
- fifo_wrfull=1 outside IDLE is ignored.
- Simultaneous RX commit and fifo_wrfull in IDLE: the mask commits and the FSM leaves to READ in the same cycle.

## Test plan
- CHANNELS=3; reset, fill FIFO with 3'b101, 3'b010, then wrfull → UART bytes 0x05, 0x02, 0x0A; trig_syncrst low again after the 0x0A is accepted.
- CHANNELS=12; one sample 12'hABC → bytes 0xBC, 0x0A (high byte), then TERM 0x0A; rdreq pulses once.
- UART acceptance delayed 5 cycles (txempty held high) → ld_tx_data stays high with uart_tx_data stable until txempty falls; no byte duplicated or skipped.
- CHANNELS=3; RX 0x4D, 0x06 while idle → uld pulses twice, one per byte; trig_mask=3'b110 within 2 cycles of the second byte. Same command during a dump → mask unchanged until FSM returns to IDLE.
- RX 0x41, then 0x4D, 0x01, 0x4D, 0x03 during a dump → 0x41 ignored; after dump trig_mask=3'b011.
- rst asserted during LOAD → next cycle all outputs at reset values; after release, INIT pulses uart_rst for 1 cycle; trig_mask=3'b111.
